// File: rtl/output_control.sv
// Bit-serial readout of the systolic core's N*N results.
// A capture latches every result into a parallel buffer, saturated to OUT_W
// bits where OUT_W < ACC_W. The buffer is then streamed LSB first, element 0
// first, one bit per clock while unload_en is high.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for capture; unload_en has no effect
// S_SHIFT | buffer loaded; one bit per clock while unload_en=1, else hold
module output_control #(
    parameter int N     = 2,
    parameter int ACC_W = 16,
    parameter int OUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*N*ACC_W-1:0]   in_z_flat,
    input  logic                   capture,
    input  logic                   unload_en,
    output logic                   data_out,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy
);

    localparam int NE     = N * N;
    localparam int BIT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ELEM_W = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(OUT_W - 1);
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(NE - 1);

    // Largest and smallest signed values representable in OUT_W bits.
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              state_q;
    logic [OUT_W-1:0]    buf_q [NE];
    logic [OUT_W-1:0]    sat_d [NE];
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [ELEM_W-1:0]   elem_cnt_q;
    logic                data_out_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                done_q;
    logic                busy_q;

    // Per-element saturation of the incoming result bus into buffer format.
    // An element fits in OUT_W bits exactly when its sign bit and every bit
    // that is dropped agree with the top kept bit; otherwise it clamps
    // towards its sign.
    for (genvar k = 0; k < NE; k++) begin : g_sat
        logic [ACC_W-1:0] elem;
        assign elem = in_z_flat[(k+1)*ACC_W-1 -: ACC_W];

        if (OUT_W == ACC_W) begin : g_copy
            assign sat_d[k] = elem[OUT_W-1:0];
        end else begin : g_clamp
            logic [ACC_W-OUT_W:0] hi;
            logic                 fits;
            assign hi       = elem[ACC_W-1:OUT_W-1];
            assign fits     = (hi == '0) || (hi == '1);
            assign sat_d[k] = fits ? elem[OUT_W-1:0]
                                   : (elem[ACC_W-1] ? SAT_MIN : SAT_MAX);
        end
    end

    // Readout FSM: capture in IDLE, serialize in SHIFT, all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < NE; k++) begin
                buf_q[k] <= '0;
            end
            bit_cnt_q   <= '0;
            elem_cnt_q  <= '0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    done_q      <= 1'b0;
                    if (capture) begin
                        for (int k = 0; k < NE; k++) begin
                            buf_q[k] <= sat_d[k];
                        end
                        bit_cnt_q  <= '0;
                        elem_cnt_q <= '0;
                        state_q    <= S_SHIFT;
                        busy_q     <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    // capture is deliberately not looked at here so a
                    // frame in flight can never be overwritten.
                    if (unload_en) begin
                        data_out_q  <= buf_q[elem_cnt_q][bit_cnt_q];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (bit_cnt_q == BIT_LAST);
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (elem_cnt_q == ELEM_LAST) begin
                                elem_cnt_q <= '0;
                                done_q     <= 1'b1;
                                state_q    <= S_IDLE;
                                busy_q     <= 1'b0;
                            end else begin
                                elem_cnt_q <= elem_cnt_q + 1'b1;
                                done_q     <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            done_q    <= 1'b0;
                        end
                    end else begin
                        // Pause: data_out, counters and buffer hold.
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_output_control.sv
// Bench for output_control: a full-width instance (OUT_W=16) and a saturating
// instance (OUT_W=8). Expected bits are queued at capture time and popped as
// the DUT emits valid bits.
module tb_output_control;

    localparam int N     = 2;
    localparam int ACC_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N*N*ACC_W-1:0] in_z_flat = '0;
    logic cap16 = 1'b0;
    logic cap8  = 1'b0;
    logic unload_en = 1'b0;

    logic d16, v16, l16, dn16, b16;
    logic d8, v8, l8, dn8, b8;

    always #5 clk = ~clk;

    output_control #(.N(N), .ACC_W(ACC_W), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_z_flat(in_z_flat), .capture(cap16),
        .unload_en(unload_en), .data_out(d16), .out_valid(v16),
        .out_last(l16), .done(dn16), .busy(b16)
    );

    output_control #(.N(N), .ACC_W(ACC_W), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_z_flat(in_z_flat), .capture(cap8),
        .unload_en(unload_en), .data_out(d8), .out_valid(v8),
        .out_last(l8), .done(dn8), .busy(b8)
    );

    typedef struct packed {
        logic d;
        logic last;
        logic done;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    int checks = 0;
    int errors = 0;
    int nbits16 = 0, nlast16 = 0, ndone16 = 0;
    int nbits8  = 0, nlast8  = 0, ndone8  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push16(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] el [4];
        exp_t x;
        el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 16; b++) begin
                x.d    = el[k][b];
                x.last = (b == 15);
                x.done = (k == 3) && (b == 15);
                q16.push_back(x);
            end
        end
    endtask

    task automatic push8(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] el [4];
        exp_t x;
        el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) begin
                x.d    = el[k][b];
                x.last = (b == 7);
                x.done = (k == 3) && (b == 7);
                q8.push_back(x);
            end
        end
    endtask

    // Scoreboard pop for the 16-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (v16) begin
                check("q16_has_entry", (q16.size() > 0), 1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    check("bit16", {d16, l16, dn16}, e);
                end
                nbits16++;
                if (l16) nlast16++;
                if (dn16) ndone16++;
            end else begin
                check("idle16_last_done", {l16, dn16}, 2'b00);
            end
        end
    end

    // Scoreboard pop for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (v8) begin
                check("q8_has_entry", (q8.size() > 0), 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check("bit8", {d8, l8, dn8}, e);
                end
                nbits8++;
                if (l8) nlast8++;
                if (dn8) ndone8++;
            end else begin
                check("idle8_last_done", {l8, dn8}, 2'b00);
            end
        end
    end

    task automatic clear_counts();
        nbits16 = 0; nlast16 = 0; ndone16 = 0;
        nbits8  = 0; nlast8  = 0; ndone8  = 0;
    endtask

    task automatic pulse_cap(input bit w8);
        @(posedge clk); #1;
        if (w8) cap8 = 1'b1; else cap16 = 1'b1;
        @(posedge clk); #1;
        cap8 = 1'b0; cap16 = 1'b0;
    endtask

    // Waits (bounded) for the done pulse; returns 1 ns after that negedge.
    task automatic wait_done(input bit w8, input string tag);
        int start;
        int n;
        start = w8 ? ndone8 : ndone16;
        n = 0;
        while (((w8 ? ndone8 : ndone16) == start) && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, (n >= 400), 0);
    endtask

    task automatic wait_bits16(input int target, input string tag);
        int n;
        n = 0;
        while (nbits16 < target && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, (n >= 400), 0);
    endtask

    initial begin
        // Reset held from time 0
        #1;
        check("rst_outputs16", {d16, v16, l16, dn16, b16}, 5'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", b16, 0);
        check("post_rst_valid", v16, 0);

        // Basic frame
        in_z_flat = {16'h1234, 16'h00FF, 16'h8000, 16'h0001};
        push16(16'h0001, 16'h8000, 16'h00FF, 16'h1234);
        clear_counts();
        pulse_cap(1'b0);
        check("basic_busy_after_cap", b16, 1);
        unload_en = 1'b1;
        wait_done(1'b0, "basic");
        check("basic_nbits", nbits16, 64);
        check("basic_nlast", nlast16, 4);
        check("basic_ndone", ndone16, 1);
        check("basic_q_empty", q16.size(), 0);
        @(negedge clk);
        check("basic_busy_fall", b16, 0);
        unload_en = 1'b0;

        // Saturating instance
        in_z_flat = {16'hFFFF, 16'h007F, 16'hFF00, 16'h0100};
        push8(8'h7F, 8'h80, 8'h7F, 8'hFF);
        clear_counts();
        pulse_cap(1'b1);
        check("sat_busy", b8, 1);
        unload_en = 1'b1;
        wait_done(1'b1, "sat");
        check("sat_nbits", nbits8, 32);
        check("sat_nlast", nlast8, 4);
        check("sat_ndone", ndone8, 1);
        check("sat_q_empty", q8.size(), 0);
        check("sat_dut16_quiet", nbits16, 0);
        @(negedge clk);
        unload_en = 1'b0;

        // Pause after bit 10, then an ignored capture mid-frame
        in_z_flat = {16'h1234, 16'h00FF, 16'h8000, 16'h0001};
        push16(16'h0001, 16'h8000, 16'h00FF, 16'h1234);
        clear_counts();
        pulse_cap(1'b0);
        unload_en = 1'b1;
        wait_bits16(11, "pause_reach");
        unload_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pause_valid", v16, 0);
            check("pause_busy", b16, 1);
        end
        check("pause_nbits_held", nbits16, 11);
        #1 unload_en = 1'b1;
        wait_bits16(30, "ign_reach");
        in_z_flat = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        pulse_cap(1'b0);
        check("ign_busy", b16, 1);
        wait_done(1'b0, "pause");
        check("pause_nbits", nbits16, 64);
        check("pause_ndone", ndone16, 1);
        check("pause_q_empty", q16.size(), 0);

        // Back-to-back: capture in the cycle after done, unload_en still high
        in_z_flat = {16'h0000, 16'hFFFF, 16'h0F0F, 16'hA5A5};
        push16(16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h0000);
        clear_counts();
        cap16 = 1'b1;
        @(posedge clk); #1;
        cap16 = 1'b0;
        @(negedge clk);
        check("b2b_no_bit_yet", v16, 0);
        check("b2b_busy", b16, 1);
        @(negedge clk);
        check("b2b_first_bit", v16, 1);
        wait_done(1'b0, "b2b");
        check("b2b_nbits", nbits16, 64);
        check("b2b_q_empty", q16.size(), 0);
        @(negedge clk);
        unload_en = 1'b0;

        // Reset at bit 20, then a fresh frame
        in_z_flat = {16'h1234, 16'h00FF, 16'h8000, 16'h0001};
        push16(16'h0001, 16'h8000, 16'h00FF, 16'h1234);
        clear_counts();
        pulse_cap(1'b0);
        unload_en = 1'b1;
        wait_bits16(20, "rst_reach");
        rst = 1'b0;
        #1;
        check("midrst_outputs", {d16, v16, l16, dn16, b16}, 5'b0);
        check("midrst_no_done", ndone16, 0);
        q16.delete();
        unload_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_idle_busy", b16, 0);
        in_z_flat = {16'h7FFF, 16'h8001, 16'h5555, 16'h00AA};
        push16(16'h00AA, 16'h5555, 16'h8001, 16'h7FFF);
        clear_counts();
        pulse_cap(1'b0);
        unload_en = 1'b1;
        wait_done(1'b0, "fresh");
        check("fresh_nbits", nbits16, 64);
        check("fresh_nlast", nlast16, 4);
        check("fresh_q_empty", q16.size(), 0);
        unload_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
